// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit for the pipelined lc3b datapath.
// Tracks in-flight destination tags and emits registered per-source forward selects.
module fwd_scoreboard #(
   parameter  int NUM_REGS     = 8,
   parameter  int NUM_SRC      = 3,
   parameter  int DEPTH        = 3,
   parameter  int LOAD_SEL_MIN = 2,
   parameter  int FLUSH_DEPTH  = 2,
   parameter  int CNT_W        = 16,
   localparam int REG_W        = $clog2(NUM_REGS),
   localparam int SEL_W        = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     advance_i,
   input  logic                     flush_i,
   input  logic                     id_valid_i,
   input  logic                     id_reg_write_i,
   input  logic                     id_is_load_i,
   input  logic [REG_W-1:0]         id_dest_i,
   input  logic [NUM_SRC*REG_W-1:0] id_src_i,
   input  logic [NUM_SRC-1:0]       id_src_used_i,
   output logic                     stall_o,
   output logic [NUM_SRC*SEL_W-1:0] fwd_sel_o,
   output logic [NUM_SRC-1:0]       fwd_hit_o,
   output logic [CNT_W-1:0]         stall_cnt_o
);

   // The WB position writes the regfile on the same edge, so it never forwards;
   // only positions 0..DEPTH-2 are kept.
   localparam int TRACK = DEPTH - 1;

   logic [TRACK-1:0]            tag_valid;
   logic [TRACK-1:0]            tag_wr;
   logic [TRACK-1:0]            tag_ld;
   logic [TRACK-1:0][REG_W-1:0] tag_dest;

   logic [NUM_SRC-1:0][SEL_W-1:0] sel_q;
   logic [NUM_SRC-1:0][SEL_W-1:0] cand_sel;
   logic [CNT_W-1:0]              cnt_q;
   logic [TRACK-1:0]              valid_n;
   logic                          load_hit;
   logic                          accept;

   // Descending scan so the youngest (lowest) matching position is written last.
   always_comb begin
      cand_sel = '0;
      load_hit = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int p = TRACK - 1; p >= 0; p--) begin
            if (id_valid_i && id_src_used_i[s] && tag_valid[p] && tag_wr[p] &&
                (tag_dest[p] == id_src_i[s*REG_W +: REG_W])) begin
               cand_sel[s] = SEL_W'(p + 1);
               if (tag_ld[p] && (p + 1 < LOAD_SEL_MIN)) load_hit = 1'b1;
            end
         end
      end
   end

   assign stall_o = load_hit & ~flush_i;
   assign accept  = id_valid_i & ~stall_o & ~flush_i;

   always_comb begin
      valid_n = '0;
      for (int p = TRACK - 1; p > 0; p--) valid_n[p] = tag_valid[p-1];
      valid_n[0] = accept;
      if (flush_i) begin
         for (int p = 0; p < TRACK; p++) begin
            if (p < FLUSH_DEPTH) valid_n[p] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid <= '0;
         tag_wr    <= '0;
         tag_ld    <= '0;
         tag_dest  <= '0;
         sel_q     <= '0;
      end else if (advance_i || flush_i) begin
         tag_valid <= valid_n;
         for (int p = TRACK - 1; p > 0; p--) begin
            tag_wr[p]   <= tag_wr[p-1];
            tag_ld[p]   <= tag_ld[p-1];
            tag_dest[p] <= tag_dest[p-1];
         end
         tag_wr[0]   <= id_reg_write_i;
         tag_ld[0]   <= id_is_load_i;
         tag_dest[0] <= id_dest_i;
         sel_q       <= accept ? cand_sel : '0;
      end
   end

   // Counts edges on which the load-use bubble is actually inserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (advance_i && stall_o && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      fwd_hit_o = '0;
      for (int s = 0; s < NUM_SRC; s++) fwd_hit_o[s] = |sel_q[s];
   end

   assign fwd_sel_o   = sel_q;
   assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Randomized and directed bench for fwd_scoreboard against an in-flight instruction list model.
module tb_fwd_scoreboard;

   localparam int NUM_REGS     = 8;
   localparam int NUM_SRC      = 3;
   localparam int DEPTH        = 3;
   localparam int LOAD_SEL_MIN = 2;
   localparam int FLUSH_DEPTH  = 2;
   localparam int SAT_W        = 10;   // narrow counter so saturation is reachable quickly
   localparam int REG_W        = 3;
   localparam int SEL_W        = 2;
   localparam int CNT_MAX      = (1 << SAT_W) - 1;

   typedef struct {
      bit v;
      bit w;
      bit ld;
      int dest;
   } rec_t;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     advance_i = 1'b0;
   logic                     flush_i = 1'b0;
   logic                     id_valid_i = 1'b0;
   logic                     id_reg_write_i = 1'b0;
   logic                     id_is_load_i = 1'b0;
   logic [REG_W-1:0]         id_dest_i = '0;
   logic [NUM_SRC*REG_W-1:0] id_src_i = '0;
   logic [NUM_SRC-1:0]       id_src_used_i = '0;
   logic                     stall_o;
   logic [NUM_SRC*SEL_W-1:0] fwd_sel_o;
   logic [NUM_SRC-1:0]       fwd_hit_o;
   logic [SAT_W-1:0]         stall_cnt_o;

   fwd_scoreboard #(
      .NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH),
      .LOAD_SEL_MIN(LOAD_SEL_MIN), .FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(SAT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .advance_i(advance_i), .flush_i(flush_i),
      .id_valid_i(id_valid_i), .id_reg_write_i(id_reg_write_i),
      .id_is_load_i(id_is_load_i), .id_dest_i(id_dest_i), .id_src_i(id_src_i),
      .id_src_used_i(id_src_used_i), .stall_o(stall_o), .fwd_sel_o(fwd_sel_o),
      .fwd_hit_o(fwd_hit_o), .stall_cnt_o(stall_cnt_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   // scoreboard state: pipe_q[0] is the youngest in-flight instruction (EX)
   rec_t                     pipe_q[$];
   logic [NUM_SRC*SEL_W-1:0] exp_q[$];
   int                       exp_sel[NUM_SRC];
   int                       exp_cnt;
   int                       n_checks = 0;
   int                       n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      rec_t b;
      b = '{v: 1'b0, w: 1'b0, ld: 1'b0, dest: 0};
      pipe_q.delete();
      exp_q.delete();
      for (int p = 0; p < DEPTH; p++) pipe_q.push_back(b);
      for (int s = 0; s < NUM_SRC; s++) exp_sel[s] = 0;
      exp_cnt = 0;
   endtask

   function automatic bit writes(int p, int src);
      return pipe_q[p].v && pipe_q[p].w && (pipe_q[p].dest == src);
   endfunction

   // One ID evaluation plus one clock edge; called just after a falling edge.
   task automatic cycle(input bit adv, input bit fl, input bit v, input bit wr, input bit ld,
                        input int dest, input int s0, input int s1, input int s2,
                        input bit [2:0] used);
      int srcs[NUM_SRC];
      int cand[NUM_SRC];
      bit exp_st;
      bit take;
      rec_t r;
      logic [NUM_SRC*SEL_W-1:0] pk;
      logic [NUM_SRC-1:0]       hk;
      srcs[0] = s0; srcs[1] = s1; srcs[2] = s2;
      advance_i      = adv;
      flush_i        = fl;
      id_valid_i     = v;
      id_reg_write_i = wr;
      id_is_load_i   = ld;
      id_dest_i      = REG_W'(dest);
      id_src_i       = {REG_W'(s2), REG_W'(s1), REG_W'(s0)};
      id_src_used_i  = used;
      #1;
      exp_st = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         cand[s] = 0;
         if (v && used[s]) begin
            for (int p = DEPTH - 2; p >= 0; p--) begin
               if (writes(p, srcs[s])) begin
                  cand[s] = p + 1;
                  if (pipe_q[p].ld && (p + 1 < LOAD_SEL_MIN)) exp_st = 1'b1;
               end
            end
         end
      end
      if (fl) exp_st = 1'b0;
      check("stall_o", stall_o, exp_st);
      if (adv || fl) begin
         take = v && !exp_st && !fl;
         r = '{v: take, w: wr, ld: ld, dest: dest};
         pipe_q.push_front(r);
         void'(pipe_q.pop_back());
         if (fl) for (int p = 0; p < FLUSH_DEPTH; p++) pipe_q[p].v = 1'b0;
         for (int s = 0; s < NUM_SRC; s++) exp_sel[s] = take ? cand[s] : 0;
         if (adv && exp_st && exp_cnt < CNT_MAX) exp_cnt++;
      end
      for (int s = 0; s < NUM_SRC; s++) pk[s*SEL_W +: SEL_W] = SEL_W'(exp_sel[s]);
      exp_q.push_back(pk);
      @(posedge clk);
      #1;
      pk = exp_q.pop_front();
      for (int s = 0; s < NUM_SRC; s++) hk[s] = (pk[s*SEL_W +: SEL_W] != 0);
      check("fwd_sel_o", fwd_sel_o, pk);
      check("fwd_hit_o", fwd_hit_o, hk);
      check("stall_cnt_o", stall_cnt_o, exp_cnt);
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", stall_o, 0);
      check("rst_sel", fwd_sel_o, 0);
      check("rst_hit", fwd_hit_o, 0);
      check("rst_cnt", stall_cnt_o, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // back-to-back ALU dependency: both sources from EX/MEM
      cycle(1, 0, 1, 1, 0, 1, 2, 3, 0, 3'b011);
      cycle(1, 0, 1, 1, 0, 2, 1, 1, 0, 3'b011);
      check("b2b_sel", fwd_sel_o, 6'h05);
      check("b2b_hit", fwd_hit_o, 3'b011);

      // one-instruction gap: MEM/WB forward, R4 not in flight
      cycle(1, 0, 1, 1, 0, 1, 2, 3, 0, 3'b011);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
      cycle(1, 0, 1, 1, 0, 3, 1, 4, 0, 3'b011);
      check("gap_sel", fwd_sel_o, 6'h02);
      // imm5 form: unused src1 aliasing R1 must not forward
      cycle(1, 0, 1, 1, 0, 1, 2, 3, 0, 3'b011);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
      cycle(1, 0, 1, 1, 0, 3, 1, 1, 0, 3'b001);
      check("imm_sel", fwd_sel_o, 6'h02);
      check("imm_hit", fwd_hit_o, 3'b001);

      // load-use: one bubble, then MEM/WB forward
      cycle(1, 0, 1, 1, 1, 5, 2, 0, 0, 3'b001);
      cycle(1, 0, 1, 1, 0, 6, 5, 2, 0, 3'b011);
      check("lu_bubble", fwd_sel_o, 0);
      cycle(1, 0, 1, 1, 0, 6, 5, 2, 0, 3'b011);
      check("lu_sel", fwd_sel_o, 6'h02);
      check("lu_cnt", stall_cnt_o, 1);

      // load-use under memory wait: frozen, then one stall
      cycle(1, 0, 1, 1, 1, 5, 2, 0, 0, 3'b001);
      repeat (4) cycle(0, 0, 1, 1, 0, 6, 5, 2, 0, 3'b011);
      check("wait_cnt", stall_cnt_o, 1);
      cycle(1, 0, 1, 1, 0, 6, 5, 2, 0, 3'b011);
      cycle(1, 0, 1, 1, 0, 6, 5, 2, 0, 3'b011);
      check("wait_sel", fwd_sel_o, 6'h02);
      check("wait_cnt2", stall_cnt_o, 2);

      // youngest writer wins, then flush clears the young positions
      cycle(1, 0, 1, 1, 0, 1, 2, 3, 0, 3'b011);
      cycle(1, 0, 1, 1, 0, 1, 2, 3, 0, 3'b011);
      cycle(1, 0, 1, 1, 0, 7, 1, 0, 0, 3'b001);
      check("young_sel", fwd_sel_o, 6'h01);
      cycle(0, 1, 1, 1, 0, 1, 2, 3, 0, 3'b011);
      check("flush_sel", fwd_sel_o, 0);
      cycle(1, 0, 1, 1, 0, 7, 1, 1, 0, 3'b011);
      check("post_flush_sel", fwd_sel_o, 0);

      // randomized traffic over a small register window to provoke hits
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               3'($urandom_range(0, 7)));
      end

      // LDR R5,[R5] repeated: stalls every other cycle until the counter saturates
      for (int i = 0; i < 2100; i++) cycle(1, 0, 1, 1, 1, 5, 5, 0, 0, 3'b001);
      check("cnt_sat", stall_cnt_o, CNT_MAX);

      // reset in the middle of a load-use stall
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
      cycle(1, 0, 1, 1, 1, 5, 2, 0, 0, 3'b001);
      id_valid_i = 1'b1; id_reg_write_i = 1'b1; id_is_load_i = 1'b0;
      id_dest_i = 3'd6; id_src_i = {3'd0, 3'd2, 3'd5}; id_src_used_i = 3'b011;
      #1;
      check("pre_rst_stall", stall_o, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_stall", stall_o, 0);
      check("async_sel", fwd_sel_o, 0);
      check("async_cnt", stall_cnt_o, 0);
      @(posedge clk);
      #1;
      check("held_rst_stall", stall_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      cycle(1, 0, 1, 1, 0, 6, 5, 2, 0, 3'b011);
      cycle(1, 0, 1, 1, 0, 1, 6, 0, 0, 3'b001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined lc3b datapath; successor to the fixed two-stage forwarding logic.
- Keeps a registered tag pipeline (valid, dest, reg_write, is_load) for every in-flight instruction from EX through WB.
- Produces registered per-source forward selects for the instruction entering EX, and a combinational load-use stall for IF/ID.
- Supports N source operands, configurable pipeline depth, load latency and flush depth, plus a saturating stall counter.

Parameters:
NUM_REGS, 8, architectural registers; REG_W = clog2(NUM_REGS)
NUM_SRC, 3, source operands checked per instruction (sr1, sr2, store source)
DEPTH, 3, tag positions tracked (pos0=EX, pos1=MEM, pos2=WB); SEL_W = clog2(DEPTH)
LOAD_SEL_MIN, 2, lowest forward select at which a load result exists (2 = MEM/WB)
FLUSH_DEPTH, 2, tag positions invalidated by flush_i after shift (includes incoming ID)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
advance_i  in  1  pipeline enable; 0 = memory wait, freeze all state
flush_i  in  1  branch/redirect squash
id_valid_i  in  1  ID holds a real instruction
id_reg_write_i  in  1  ID instruction writes id_dest_i
id_is_load_i  in  1  ID instruction is LDR/LDB/LDI
id_dest_i  in  REG_W  ID destination register
id_src_i  in  NUM_SRC*REG_W  ID source registers, src s at [s*REG_W +: REG_W]
id_src_used_i  in  NUM_SRC  source s is actually read (0 for imm5/offset forms)
stall_o  out  1  load-use hazard; hold PC and IF/ID, bubble into EX
fwd_sel_o  out  NUM_SRC*SEL_W  per-source select for the EX instruction: 0 = regfile/ID_EX latch, k = pipeline register after stage k (1 = EX/MEM, 2 = MEM/WB)
fwd_hit_o  out  1*NUM_SRC  per-source fwd_sel_o != 0
stall_cnt_o  out  CNT_W  cycles with stall_o & advance_i, saturating

Behaviour:
- Reset (async, rst_n=0): all tag valids 0, fwd_sel_o=0, fwd_hit_o=0, stall_cnt_o=0. stall_o=0 follows, since no tags are valid.
- Tag match at position p for source s: tag[p].valid & tag[p].reg_write & tag[p].dest == src_s & id_src_used_i[s] & id_valid_i.
  - Only p in 0..DEPTH-2 are compared.
  - Position DEPTH-1 (WB) writes the regfile at this edge, so it needs no forward.
- Youngest match (lowest p) wins; candidate select = p+1.
- stall_o (combinational) = OR over s of a match at p where tag[p].is_load and p+1 < LOAD_SEL_MIN.
  - Independent of advance_i.
  - Forced 0 when flush_i=1.
- Clock edge with advance_i=0 and flush_i=0: all registers hold, including fwd_sel_o and stall_cnt_o.
- Clock edge with advance_i=1 or flush_i=1:
  - Tags shift: pos[p+1] <= pos[p]; pos[DEPTH-1] retires.
  - pos0 <= ID tag if (!stall_o & !flush_i), else bubble (valid=0).
  - fwd_sel_o/fwd_hit_o <= candidate selects if pos0 loads a real tag, else 0.
- flush_i: after the shift, positions 0..FLUSH_DEPTH-1 are invalid and fwd_sel_o=0. Flush overrides stall and takes effect even when advance_i=0.
- Stall then resolve: a bubble enters EX. Next cycle the load sits at pos1, the match gives select 2 and stall_o drops.
- Simultaneous matches at several positions: lowest p only. Multiple sources may select different stages in the same cycle.
- A dest matching its own src in the same ID instruction has no effect; only older tags are compared.
- stall_cnt_o increments on edges with advance_i & stall_o & !flush_i, and holds at 2^CNT_W-1.
- Reset asserted mid-stall: all outputs return to reset values immediately (async). No partial tags survive.
- Latency: selects are valid in the cycle the instruction is in EX, one edge after ID evaluation. stall_o has zero latency.

Test Plan:
- ADD R1 then ADD R2,R1,R1 back-to-back, advance=1 -> in EX cycle fwd_sel src0=src1=1, fwd_hit=3'b011, stall_o=0.
- ADD R1; NOP; AND R3,R1,R4 -> src0 sel=2, src1 sel=0. Same with imm5 form (src_used[1]=0) and R4 aliasing R1 -> src1 sel=0.
- LDR R5 then ADD R6,R5,R2 -> stall_o=1 for exactly one cycle, a bubble in EX (sel=0), then ADD in EX with src0 sel=2; stall_cnt_o=1.
- Same load-use hazard with advance_i=0 for 4 cycles -> stall_o stays 1, tags and stall_cnt_o frozen. After advance resumes: one stall cycle, then sel=2.
- Two writers to R1 at pos0 and pos1, consumer reads R1 -> sel=1 (youngest wins). Then flush_i=1 -> pos0/pos1 invalid, next consumer of R1 gets sel=0.
- Force 65540 stall cycles with CNT_W=16 -> stall_cnt_o saturates at 16'hFFFF. Pulse rst_n low mid-stall -> stall_o, fwd_sel_o and stall_cnt_o read 0 before the next clk edge.
